// File: rtl/score_sequencer.sv
// score_sequencer: song-level controller for the pitch scoring datapath.
// Pulls one sung/ref pair per note, pulses the comparator start, waits for
// its score (or a timeout), and accumulates a saturating song total.
// Optional build macro: SCORE_SEQ_STREAK_EN adds the longest-run-of-10s tracker.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | no song running; totals hold the previous song's results
// WAIT_DATA  | waiting for both frequency FIFOs to hold a pair
// START      | cmp_start pulse is high; timeout timer is loaded
// WAIT_SCORE | waiting for cmp_score_ready or timer terminal count
// ACCUM      | last_score added into total_score, note_count advanced
// DONE       | song_done pulse; back to IDLE next cycle
module score_sequencer #(
  parameter int NUM_NOTES   = 64,
  parameter int CNT_W       = 8,
  parameter int TOTAL_W     = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               song_start,
  input  logic               song_abort,
  input  logic               pair_valid,
  input  logic               cmp_score_ready,
  input  logic [3:0]         cmp_score,
  output logic               cmp_enable,
  output logic               cmp_start,
  output logic               busy,
  output logic               song_done,
  output logic [TOTAL_W-1:0] total_score,
  output logic [CNT_W-1:0]   note_count,
  output logic [3:0]         last_score,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   max_streak
);

  localparam int                 TMR_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]   LAST_NOTE = CNT_W'(NUM_NOTES - 1);
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, START, WAIT_SCORE, ACCUM, DONE
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [TOTAL_W:0]   sum_wide;
  logic [TOTAL_W-1:0] total_next;

  // The timer is a down-counter loaded in START; reaching zero in WAIT_SCORE
  // lines up with TIMEOUT_CYC elapsed cycles of an incrementing count.
  assign sum_wide   = {1'b0, total_score} + {{(TOTAL_W-3){1'b0}}, last_score};
  assign total_next = sum_wide[TOTAL_W] ? TOTAL_MAX : sum_wide[TOTAL_W-1:0];

  // Sequencer FSM with registered outputs; abort from any active state wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      cmp_enable  <= 1'b0;
      cmp_start   <= 1'b0;
      busy        <= 1'b0;
      song_done   <= 1'b0;
      total_score <= '0;
      note_count  <= '0;
      last_score  <= '0;
      timeout_err <= 1'b0;
    end else begin
      cmp_start <= 1'b0;
      song_done <= 1'b0;
      if (song_abort && (state != IDLE)) begin
        state      <= IDLE;
        busy       <= 1'b0;
        cmp_enable <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (song_start && !song_abort) begin
              state       <= WAIT_DATA;
              busy        <= 1'b1;
              cmp_enable  <= 1'b1;
              total_score <= '0;
              note_count  <= '0;
              last_score  <= '0;
              timeout_err <= 1'b0;
            end
          end
          WAIT_DATA: begin
            if (pair_valid) begin
              state     <= START;
              cmp_start <= 1'b1;
            end
          end
          START: begin
            timer <= TMR_LOAD;
            state <= WAIT_SCORE;
          end
          WAIT_SCORE: begin
            timer <= timer - 1'b1;
            if (cmp_score_ready) begin
              last_score <= cmp_score;
              state      <= ACCUM;
            end else if (timer == '0) begin
              last_score  <= '0;
              timeout_err <= 1'b1;
              state       <= ACCUM;
            end
          end
          ACCUM: begin
            total_score <= total_next;
            note_count  <= note_count + 1'b1;
            if (note_count == LAST_NOTE) begin
              state      <= DONE;
              song_done  <= 1'b1;
              busy       <= 1'b0;
              cmp_enable <= 1'b0;
            end else begin
              state <= WAIT_DATA;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef SCORE_SEQ_STREAK_EN
  localparam logic [3:0] SCORE_MAX = 4'd10;

  logic [CNT_W-1:0] cur_streak;
  logic [CNT_W-1:0] streak_inc;

  assign streak_inc = cur_streak + 1'b1;

  // Tracks the current and longest run of perfect notes within a song.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_streak <= '0;
      max_streak <= '0;
    end else if ((state == IDLE) && song_start && !song_abort) begin
      cur_streak <= '0;
      max_streak <= '0;
    end else if ((state == ACCUM) && !song_abort) begin
      if (last_score == SCORE_MAX) begin
        cur_streak <= streak_inc;
        if (streak_inc > max_streak) begin
          max_streak <= streak_inc;
        end
      end else begin
        cur_streak <= '0;
      end
    end
  end
`else
  assign max_streak = '0;
`endif

endmodule
